cam_capture_core: RTL and testbench
===================================

CAM_CAPTURE_CORE -- requirements
Module: cam_capture_core

Interface
REQ-001 The block SHALL have parameter BYTES_PER_PIX, default 2, meaning sensor bytes per pixel (1 = RAW8/Y, 2 = RGB565/YUV422); legal values are 1 and 2.
REQ-002 The block SHALL have parameter H_ACTIVE, default 320, meaning the maximum pixels accepted per line.
REQ-003 The block SHALL have parameter V_ACTIVE, default 240, meaning the maximum lines accepted per frame.
REQ-004 The block SHALL have parameter DECIM, default 1, meaning the decimation factor applied to both x and y; legal values are 1, 2 and 4.
REQ-005 Port pclk_24, input, 1 bit: 24 MHz pixel clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port start, input, 1 bit: capture enable; asynchronous to pclk_24.
REQ-008 Ports vsync, href and d, inputs of widths 1, 1 and 8: sensor frame sync, line-valid and data byte.
REQ-009 Port pix_data, output, BYTES_PER_PIX*8 bits: assembled pixel; the first byte of each pixel occupies the MSBs.
REQ-010 Ports pix_valid (output, 1 bit) and pix_ready (input, 1 bit) form the downstream handshake.
REQ-011 Ports pix_x (output, 10 bits) and pix_y (output, 9 bits) give the post-decimation coordinates of pix_data.
REQ-012 Ports pix_sof and pix_sol, outputs of 1 bit each, flag the first pixel of a frame and the first pixel of a line, respectively.
REQ-013 Ports frame_done (output, 1 bit) and frame_cnt (output, 8 bits) give the end-of-frame pulse and the completed-frame count.
REQ-014 Port overflow, output, 1 bit: sticky flag indicating that a pixel was dropped.

Function
REQ-015 The start input SHALL pass through a two-flop synchroniser; the synchronised signal is start_s.
REQ-016 The FSM SHALL have the states IDLE, WAIT_VS, WAIT_VS_LOW and ACTIVE.
REQ-017 IDLE SHALL go to WAIT_VS when start_s=1; WAIT_VS SHALL go to WAIT_VS_LOW on vsync=1; WAIT_VS_LOW SHALL go to ACTIVE on vsync=0.
REQ-018 Capture SHALL therefore always begin at a frame boundary, never mid-frame.
REQ-019 On vsync=1 in ACTIVE, the block SHALL pulse frame_done for one cycle and increment frame_cnt, wrapping 255->0.
REQ-020 After that frame end, the FSM SHALL go to WAIT_VS_LOW if start_s=1, else to IDLE.
REQ-021 When start_s deasserts in ACTIVE, the current frame SHALL complete before the FSM returns to IDLE.
REQ-022 In ACTIVE with href=1, d SHALL be sampled on every clock; a byte counter SHALL assemble BYTES_PER_PIX bytes into one pixel.
REQ-023 A falling edge of href SHALL reset the byte counter and x, increment y, and discard any partial pixel.
REQ-024 Raw x (saturating at H_ACTIVE) and raw y (saturating at V_ACTIVE) SHALL count source pixels and lines; pixels with x>=H_ACTIVE or y>=V_ACTIVE SHALL be dropped silently, without setting overflow.
REQ-025 A pixel SHALL be kept only when raw x mod DECIM = 0 and raw y mod DECIM = 0; pix_x = x/DECIM and pix_y = y/DECIM.
REQ-026 Latency: pix_valid SHALL assert on the cycle after the last byte of a kept pixel is sampled.
REQ-027 pix_valid SHALL hold, with pix_data, pix_x, pix_y, pix_sof and pix_sol stable, until a cycle with pix_ready=1.
REQ-028 A one-entry output register SHALL be used: a new pixel completing while pix_valid=1 and pix_ready=0 SHALL be dropped and overflow SHALL be set.
REQ-029 When pix_valid=1 and pix_ready=1 coincide with a new pixel completing, the new pixel SHALL be loaded with no drop.
REQ-030 pix_sof SHALL be 1 only for kept pixel (0,0) of each frame; pix_sol SHALL be 1 for each kept pixel with pix_x=0.
REQ-031 overflow SHALL be cleared only on entry to IDLE or by reset.
REQ-032 vsync=1 mid-line SHALL terminate the frame per REQ-019/REQ-020; a pending pix_valid SHALL still complete its handshake.

Reset
REQ-033 On reset_n=0 at a clock edge, the FSM SHALL enter IDLE and all counters and the synchroniser SHALL clear.
REQ-034 During reset, pix_valid, pix_sof, pix_sol, frame_done and overflow SHALL be 0, and pix_data, pix_x, pix_y and frame_cnt SHALL be 0.
REQ-035 A reset mid-frame SHALL abort immediately, discarding any pending pixel.

Structure
REQ-036 Package cam_capture_pkg SHALL hold the FSM state typedef, the X_W=10 and Y_W=9 width constants, and the legal-value checks for DECIM and BYTES_PER_PIX.
REQ-037 Sub-module cdc_sync_2ff SHALL implement the start synchroniser; all other logic SHALL reside in cam_capture_core.

Verification
REQ-038 Defaults, start=1, one 4-line frame of 320 pixels at 640 bytes/line with d = incrementing bytes, pix_ready=1 -> first pixel 0x0001 with pix_sof=1, 1280 pixels total, frame_done=1, frame_cnt=1.
REQ-039 Start asserted mid-frame -> no pix_valid until after the next vsync high->low; the first pixel out has pix_sof=1.
REQ-040 pix_ready=0 for 10 cycles across 3 completing pixels -> the first pixel holds, the next 2 are dropped, overflow=1, and it stays 1 until start=0 returns the FSM to IDLE.
REQ-041 DECIM=2, 8x4 source frame -> 8 pixels out, coordinates (0..3, 0..1), sourced from even raw x and y.
REQ-042 BYTES_PER_PIX=2 with href dropped after 3 bytes -> 1 pixel out, odd byte discarded, next line pix_x=0 with pix_sol=1.
REQ-043 257 frames -> frame_cnt wraps to 1; reset_n=0 mid-line -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/cam_capture_pkg.sv
// rtl/cam_capture_pkg.sv - shared state type, widths and parameter checks for the camera capture core
package cam_capture_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    WAIT_VS_LOW,
    ACTIVE
  } cap_state_e;

  function automatic bit decim_legal(input int decim);
    return (decim == 1) || (decim == 2) || (decim == 4);
  endfunction

  function automatic bit bpp_legal(input int bpp);
    return (bpp == 1) || (bpp == 2);
  endfunction

  // Decimation is a power of two, so divide and modulo become shift and mask.
  function automatic int decim_shift(input int decim);
    return (decim == 4) ? 2 : (decim == 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/cam_capture_cdc_sync_2ff.sv
// rtl/cam_capture_cdc_sync_2ff.sv - two-flop level synchroniser for the capture enable
module cdc_sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= level;
      synced <= meta;
    end
  end

endmodule

// File: rtl/cam_capture_core.sv
// rtl/cam_capture_core.sv - DVP-style sensor capture: frame-aligned start, pixel assembly,
// decimation and a one-entry valid/ready output register
module cam_capture_core
  import cam_capture_pkg::*;
#(
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 320,
  parameter int V_ACTIVE      = 240,
  parameter int DECIM         = 1
) (
  input  logic                       pclk_24,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 d,
  output logic [BYTES_PER_PIX*8-1:0] pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [X_W-1:0]             pix_x,
  output logic [Y_W-1:0]             pix_y,
  output logic                       pix_sof,
  output logic                       pix_sol,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic                       overflow
);

  if (!decim_legal(DECIM)) begin : g_bad_decim
    $error("cam_capture_core: DECIM must be 1, 2 or 4");
  end
  if (!bpp_legal(BYTES_PER_PIX)) begin : g_bad_bpp
    $error("cam_capture_core: BYTES_PER_PIX must be 1 or 2");
  end

  localparam int             DSH    = decim_shift(DECIM);
  localparam logic [X_W-1:0] X_MAX  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] X_MASK = X_W'(DECIM - 1);
  localparam logic [Y_W-1:0] Y_MASK = Y_W'(DECIM - 1);

  cap_state_e state_q, state_d;
  logic       start_s;

  logic           href_q;
  logic           byte_cnt_q;
  logic [7:0]     byte_hi_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  logic active, frame_end, sample, line_end, last_byte, keep, enter_idle;
  logic [BYTES_PER_PIX*8-1:0] assembled;

  cdc_sync_2ff u_start_sync (
    .clk     (pclk_24),
    .reset_n (reset_n),
    .level   (start),
    .synced  (start_s)
  );

  always_ff @(posedge pclk_24) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (start_s) state_d = WAIT_VS;
      WAIT_VS:     if (vsync)   state_d = WAIT_VS_LOW;
      WAIT_VS_LOW: if (!vsync)  state_d = ACTIVE;
      ACTIVE:      if (vsync)   state_d = start_s ? WAIT_VS_LOW : IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign active     = (state_q == ACTIVE);
  assign frame_end  = active && vsync;
  assign sample     = active && !vsync && href;
  assign line_end   = active && !vsync && href_q && !href;
  assign last_byte  = (BYTES_PER_PIX == 1) || byte_cnt_q;
  assign enter_idle = (state_d == IDLE) && (state_q != IDLE);

  // Out-of-window pixels fall out here without touching overflow.
  assign keep = sample && last_byte && (x_q < X_MAX) && (y_q < Y_MAX) &&
                ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0);

  if (BYTES_PER_PIX == 2) begin : g_two_byte
    assign assembled = {byte_hi_q, d};
  end else begin : g_one_byte
    assign assembled = d;
  end

  // Raw source position; cleared outside ACTIVE so every frame starts at (0,0).
  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      href_q     <= 1'b0;
      byte_cnt_q <= 1'b0;
      byte_hi_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      href_q <= href;
      if (!active) begin
        byte_cnt_q <= 1'b0;
        x_q        <= '0;
        y_q        <= '0;
      end else if (line_end) begin
        byte_cnt_q <= 1'b0;
        x_q        <= '0;
        if (y_q != Y_MAX) y_q <= y_q + 1'b1;
      end else if (sample) begin
        byte_cnt_q <= !last_byte;
        if (!last_byte) byte_hi_q <= d;
        if (last_byte && (x_q != X_MAX)) x_q <= x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_sol    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;

      if (keep && (!pix_valid || pix_ready)) begin
        pix_valid <= 1'b1;
        pix_data  <= assembled;
        pix_x     <= x_q >> DSH;
        pix_y     <= y_q >> DSH;
        pix_sof   <= (x_q == '0) && (y_q == '0);
        pix_sol   <= (x_q == '0);
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end

      if (enter_idle)                        overflow <= 1'b0;
      else if (keep && pix_valid && !pix_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_capture_core.sv
// tb/tb_cam_capture_core.sv - scoreboard bench for cam_capture_core (default and DECIM=2 instances)
module tb_cam_capture_core;

  typedef struct packed {
    logic [15:0] data;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sof;
    logic        sol;
  } pix_t;

  logic       pclk_24 = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       vsync   = 1'b0;
  logic       href    = 1'b0;
  logic [7:0] d       = 8'h00;
  logic       ready_a = 1'b1;
  logic       ready_b = 1'b1;

  logic [15:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic [9:0]  x_a, x_b;
  logic [8:0]  y_a, y_b;
  logic        sof_a, sof_b, sol_a, sol_b;
  logic        fd_a_pulse, fd_b_pulse;
  logic [7:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;

  int   checks = 0;
  int   errors = 0;
  pix_t qa[$];
  pix_t qb[$];
  int   popped_a = 0;
  int   popped_b = 0;
  int   fd_a = 0;
  pix_t got_a, exp_a, got_b, exp_b;

  cam_capture_core u_dut_a (
    .pclk_24 (pclk_24), .reset_n (reset_n), .start (start_a),
    .vsync (vsync), .href (href), .d (d),
    .pix_data (data_a), .pix_valid (valid_a), .pix_ready (ready_a),
    .pix_x (x_a), .pix_y (y_a), .pix_sof (sof_a), .pix_sol (sol_a),
    .frame_done (fd_a_pulse), .frame_cnt (cnt_a), .overflow (ovf_a)
  );

  cam_capture_core #(.DECIM(2)) u_dut_b (
    .pclk_24 (pclk_24), .reset_n (reset_n), .start (start_b),
    .vsync (vsync), .href (href), .d (d),
    .pix_data (data_b), .pix_valid (valid_b), .pix_ready (ready_b),
    .pix_x (x_b), .pix_y (y_b), .pix_sof (sof_b), .pix_sol (sol_b),
    .frame_done (fd_b_pulse), .frame_cnt (cnt_b), .overflow (ovf_b)
  );

  initial forever #5 pclk_24 = ~pclk_24;

  always @(negedge pclk_24) begin
    if (reset_n && valid_a && ready_a) begin
      got_a  = {data_a, x_a, y_a, sof_a, sol_a};
      checks = checks + 1;
      if (qa.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_a unexpected: got data=%h x=%0d y=%0d, required no pixel", data_a, x_a, y_a);
      end else begin
        exp_a    = qa.pop_front();
        popped_a = popped_a + 1;
        if (got_a !== exp_a) begin
          errors = errors + 1;
          $display("FAIL sb_a pixel: got data=%h x=%0d y=%0d sof=%b sol=%b, required data=%h x=%0d y=%0d sof=%b sol=%b",
                   got_a.data, got_a.x, got_a.y, got_a.sof, got_a.sol,
                   exp_a.data, exp_a.x, exp_a.y, exp_a.sof, exp_a.sol);
        end
      end
    end
    if (reset_n && fd_a_pulse) fd_a = fd_a + 1;
  end

  always @(negedge pclk_24) begin
    if (reset_n && valid_b && ready_b) begin
      got_b  = {data_b, x_b, y_b, sof_b, sol_b};
      checks = checks + 1;
      if (qb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_b unexpected: got data=%h x=%0d y=%0d, required no pixel", data_b, x_b, y_b);
      end else begin
        exp_b    = qb.pop_front();
        popped_b = popped_b + 1;
        if (got_b !== exp_b) begin
          errors = errors + 1;
          $display("FAIL sb_b pixel: got data=%h x=%0d y=%0d sof=%b sol=%b, required data=%h x=%0d y=%0d sof=%b sol=%b",
                   got_b.data, got_b.x, got_b.y, got_b.sof, got_b.sol,
                   exp_b.data, exp_b.x, exp_b.y, exp_b.sof, exp_b.sol);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk_24);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [15:0] data, input int x, input int y, input bit sof, input bit sol);
    qa.push_back({data, 10'(x), 9'(y), sof, sol});
  endtask

  task automatic push_b(input logic [15:0] data, input int x, input int y, input bit sof, input bit sol);
    qb.push_back({data, 10'(x), 9'(y), sof, sol});
  endtask

  task automatic line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      d    = base + 8'(i);
      tick(1);
    end
    href = 1'b0;
    tick(4);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(valid_a), 0);
    check({tag, "_data"}, int'(data_a), 0);
    check({tag, "_xy"}, int'({x_a, y_a}), 0);
    check({tag, "_flags"}, int'({sof_a, sol_a, fd_a_pulse, ovf_a}), 0);
    check({tag, "_frame_cnt"}, int'(cnt_a), 0);
  endtask

  initial begin
    tick(3);
    check_all_zero("reset");
    check("reset_b_valid", int'(valid_b), 0);
    reset_n = 1'b1;
    tick(2);

    // Full default frame: 4 lines x 320 pixels, bytes counting from 0 in each line.
    start_a = 1'b1;
    tick(5);
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 320; p++) push_a({8'(2 * p), 8'(2 * p + 1)}, p, l, (p == 0) && (l == 0), p == 0);
      line(640, 8'h00);
    end
    vsync_pulse();
    check("frame1_pixels", popped_a, 1280);
    check("frame1_done", fd_a, 1);
    check("frame1_cnt", int'(cnt_a), 1);
    check("frame1_ovf", int'(ovf_a), 0);

    // Partial pixel at line end is discarded; next line restarts at x=0.
    push_a(16'h1011, 0, 0, 1, 1);
    line(3, 8'h10);
    push_a(16'h2021, 0, 1, 0, 1);
    push_a(16'h2223, 1, 1, 0, 0);
    line(4, 8'h20);
    vsync_pulse();
    check("frame2_queue", qa.size(), 0);
    check("frame2_cnt", int'(cnt_a), 2);

    // Back-pressure across three pixels: first holds, two dropped, overflow sticks.
    ready_a = 1'b0;
    push_a(16'h3031, 0, 0, 1, 1);
    line(6, 8'h30);
    check("stall_valid", int'(valid_a), 1);
    check("stall_ovf", int'(ovf_a), 1);
    ready_a = 1'b1;
    push_a(16'h5051, 0, 1, 0, 1);
    push_a(16'h5253, 1, 1, 0, 0);
    line(4, 8'h50);
    check("ovf_sticky", int'(ovf_a), 1);
    start_a = 1'b0;
    tick(4);
    vsync_pulse();
    check("ovf_cleared_idle", int'(ovf_a), 0);
    check("frame3_cnt", int'(cnt_a), 3);
    check("frame3_queue", qa.size(), 0);

    // Start raised mid-frame: nothing until the next vsync falls.
    vsync_pulse();
    line(8, 8'h00);
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      d    = 8'(i);
      if (i == 3) start_a = 1'b1;
      tick(1);
    end
    href = 1'b0;
    tick(4);
    line(8, 8'h60);
    check("midstart_no_pix", popped_a, 1280 + 3 + 3);
    vsync_pulse();
    push_a(16'h4041, 0, 0, 1, 1);
    push_a(16'h4243, 1, 0, 0, 0);
    line(4, 8'h40);
    check("midstart_queue", qa.size(), 0);
    check("midstart_popped", popped_a, 1280 + 3 + 3 + 2);

    // Frame counter wrap after 257 frames.
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    fd_a    = 0;
    tick(5);
    vsync_pulse();
    for (int f = 0; f < 257; f++) begin
      vsync = 1'b1;
      tick(1);
      vsync = 1'b0;
      tick(2);
    end
    check("wrap_done_pulses", fd_a, 257);
    check("wrap_cnt", int'(cnt_a), 1);

    // Reset mid-line with a pixel pending.
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      href = 1'b1;
      d    = 8'h70 + 8'(i);
      tick(1);
    end
    check("pending_valid", int'(valid_a), 1);
    reset_n = 1'b0;
    tick(1);
    check_all_zero("midreset");
    reset_n = 1'b1;
    href    = 1'b0;
    ready_a = 1'b1;
    start_a = 1'b0;
    tick(4);
    check("midreset_queue", qa.size(), 0);

    // DECIM=2 instance: 8x4 source frame keeps even x on even lines.
    start_b = 1'b1;
    tick(5);
    vsync_pulse();
    for (int l = 0; l < 4; l++) begin
      if (l % 2 == 0)
        for (int x = 0; x < 8; x += 2)
          push_b({8'(l * 16 + 2 * x), 8'(l * 16 + 2 * x + 1)}, x / 2, l / 2, (x == 0) && (l == 0), x == 0);
      line(16, 8'(l * 16));
    end
    vsync_pulse();
    check("decim_pixels", popped_b, 8);
    check("decim_queue", qb.size(), 0);
    check("decim_cnt", int'(cnt_b), 1);
    start_b = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
